// File: rtl/jt12_kon_pkg.sv
// jt12_kon_pkg
// Shared definitions for the key-on scheduler:
//   SLOTS        - slots per frame for the default six-channel build
//   SLOT_W       - width of the slot index
//   GRP_OP_BIT   - operator group (slot order S1,S3,S2,S4) to op-bit map
//   kon_cmd_t    - queued command {ch_idx, op}
//   ch_decode()  - YM2612 channel code to {valid, idx}
package jt12_kon_pkg;

    localparam int NUM_CH_DEF = 6;
    localparam int SLOTS      = 4 * NUM_CH_DEF;
    localparam int SLOT_W     = 5;

    // Slots are grouped by operator in the order S1, S3, S2, S4, while the
    // command carries op bits in S1, S2, S3, S4 order.
    localparam int GRP_OP_BIT [4] = '{0, 2, 1, 3};

    typedef struct packed {
        logic [2:0] ch_idx;
        logic [3:0] op;
    } kon_cmd_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } ch_dec_t;

    // Codes 0..2 are ch0..2, codes 4..6 are ch3..5; 3 and 7 are holes.
    function automatic ch_dec_t ch_decode(input logic [2:0] code);
        ch_dec_t d;
        d.valid = (code[1:0] != 2'b11);
        d.idx   = code[2] ? (3'(code[1:0]) + 3'd3) : 3'(code[1:0]);
        return d;
    endfunction

endpackage

// File: rtl/jt12_kon_fifo.sv
// jt12_kon_fifo
// Small synchronous FIFO holding pending key-on commands.
//   clk, rst_n  - clock, asynchronous active-low reset (flushes pointers)
//   push, wdata - write strobe and data; ignored when full
//   pop         - read strobe; ignored when empty
//   rdata       - head entry (valid while !empty)
//   full, empty - status from the registered level
//   level       - number of entries held, 0..DEPTH
module jt12_kon_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 7,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // The head has to be visible in the same cycle as the frame strobe
    // that consumes it, so the read is combinational from the small array.
    assign rdata = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/jt12_kon_sched.sv
// jt12_kon_sched
// Key-on scheduler: buffers channel key commands and applies at most one
// per frame, serialising the per-slot key bit in step with the EG pipeline.
//   clk, rst_n        - clock, asynchronous active-low reset
//   clk_en            - slot advance enable (gates slot, kon, pop, keyon_I)
//   zero              - frame marker; resynchronises slot to 0 and applies
//   cmd_valid/ready   - command handshake (independent of clk_en)
//   cmd_ch, cmd_op    - YM2612 channel code and S1..S4 key bits
//   keyon_I           - key state of the slot shown on `slot`
//   slot              - current slot index
//   fifo_lvl          - queued commands
//   drop_err          - one-cycle pulse after an invalid channel is consumed
module jt12_kon_sched
    import jt12_kon_pkg::*;
#(
    parameter int NUM_CH     = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_en,
    input  logic                          zero,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_ch,
    input  logic [3:0]                    cmd_op,
    output logic                          keyon_I,
    output logic [SLOT_W-1:0]             slot,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl,
    output logic                          drop_err
);

    localparam int NSLOT = 4 * NUM_CH;

    ch_dec_t               dec;
    logic                  ch_ok;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$bits(kon_cmd_t)-1:0] fifo_rdata;
    kon_cmd_t              wr_cmd;
    kon_cmd_t              head;

    logic [NSLOT-1:0]      kon_reg;
    logic [NSLOT-1:0]      kon_next;
    logic [SLOT_W-1:0]     slot_reg;
    logic [SLOT_W-1:0]     slot_next;
    logic                  keyon_reg;
    logic                  drop_reg;

    // ------------------------------------------------------------------
    // Handshake and channel decode
    // ------------------------------------------------------------------
    // Ready comes from the registered level only, so a same-cycle pop
    // never opens room for a push into a full FIFO.
    assign cmd_ready = !fifo_full;
    assign dec       = ch_decode(cmd_ch);
    assign ch_ok     = dec.valid && (int'(dec.idx) < NUM_CH);
    assign accept    = cmd_valid && cmd_ready;
    assign push      = accept && ch_ok;

    assign wr_cmd.ch_idx = dec.idx;
    assign wr_cmd.op     = cmd_op;

    // Apply strobe: one entry per frame boundary while slots advance.
    assign pop  = clk_en && zero && !fifo_empty;
    assign head = kon_cmd_t'(fifo_rdata);

    jt12_kon_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(kon_cmd_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_cmd),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_lvl)
    );

    // ------------------------------------------------------------------
    // Key register update: each slot knows its own channel and operator
    // group at elaboration time, so the write is a per-slot compare.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            localparam int GRP = gi / NUM_CH;
            localparam int CH  = gi % NUM_CH;
            localparam int OPB = GRP_OP_BIT[GRP];
            assign kon_next[gi] = (pop && (head.ch_idx == 3'(CH)))
                                ? head.op[OPB] : kon_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Slot counter: zero always wins, otherwise count and wrap.
    // ------------------------------------------------------------------
    always_comb begin
        slot_next = slot_reg + 1'b1;
        if (zero) begin
            slot_next = '0;
        end else if (slot_reg == SLOT_W'(NSLOT - 1)) begin
            slot_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // State registers. keyon_I looks at kon_next so that the frame in
    // which a command is applied already carries the new key state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kon_reg   <= '0;
            slot_reg  <= '0;
            keyon_reg <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            drop_reg <= accept && !ch_ok;
            if (clk_en) begin
                kon_reg   <= kon_next;
                slot_reg  <= slot_next;
                keyon_reg <= kon_next[slot_next];
            end
        end
    end

    assign keyon_I  = keyon_reg;
    assign slot     = slot_reg;
    assign drop_err = drop_reg;

endmodule

// File: tb/tb_jt12_kon_sched.sv
module tb_jt12_kon_sched;

    localparam int NCH   = 6;
    localparam int DEPTH = 4;
    localparam int NS    = 4 * NCH;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clk_en = 1'b0;
    logic       zero = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_ch = '0;
    logic [3:0] cmd_op = '0;
    logic       cmd_ready;
    logic       keyon_I;
    logic [4:0] slot;
    logic [2:0] fifo_lvl;
    logic       drop_err;

    always #5 clk = ~clk;

    jt12_kon_sched #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .zero      (zero),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ch    (cmd_ch),
        .cmd_op    (cmd_op),
        .keyon_I   (keyon_I),
        .slot      (slot),
        .fifo_lvl  (fifo_lvl),
        .drop_err  (drop_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of decoded commands, one key bit per slot.
    typedef struct {
        int       ch;
        bit [3:0] op;
    } cmd_t;

    cmd_t m_q[$];
    bit   m_kon[NS];
    int   m_slot;
    int   m_key;
    int   m_drop;
    int   chmap [8] = '{0, 1, 2, -1, 3, 4, 5, -1};
    // Slot groups in time order are S1, S3, S2, S4.
    int   grp_op [4] = '{0, 2, 1, 3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("slot", slot, m_slot);
        chk("keyon_I", keyon_I, m_key);
        chk("fifo_lvl", fifo_lvl, m_q.size());
        chk("drop_err", drop_err, m_drop);
        chk("cmd_ready_post", cmd_ready, m_q.size() < DEPTH);
    endtask

    // One clock: drive, check ready before the edge, update model, check.
    task automatic tick(input bit v, input bit [2:0] ch, input bit [3:0] op,
                        input bit en, input bit z);
        bit   acc;
        bit   pop;
        cmd_t c;
        cmd_valid = v;
        cmd_ch    = ch;
        cmd_op    = op;
        clk_en    = en;
        zero      = z;
        #1;
        chk("cmd_ready", cmd_ready, m_q.size() < DEPTH);
        acc = v && (m_q.size() < DEPTH);
        pop = en && z && (m_q.size() > 0);
        @(posedge clk);
        m_drop = 0;
        if (pop) begin
            c = m_q.pop_front();
            for (int g = 0; g < 4; g++) m_kon[g * NCH + c.ch] = c.op[grp_op[g]];
        end
        if (acc) begin
            if (chmap[ch] >= 0) begin
                c.ch = chmap[ch];
                c.op = op;
                m_q.push_back(c);
            end else begin
                m_drop = 1;
            end
        end
        if (en) begin
            m_slot = z ? 0 : (m_slot + 1) % NS;
            m_key  = m_kon[m_slot];
        end
        #1;
        check_outputs();
    endtask

    // Free-running frame: zero accompanies the last slot of each frame.
    task automatic ftick(input bit v, input bit [2:0] ch, input bit [3:0] op);
        tick(v, ch, op, 1'b1, m_slot == NS - 1);
    endtask

    task automatic frames(input int n);
        repeat (n * NS) ftick(1'b0, 3'd0, 4'd0);
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 2 * NS; i++) begin
            if (slot === 5'(s)) break;
            ftick(1'b0, 3'd0, 4'd0);
        end
        chk("wait_slot", slot, s);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        clk_en    = 1'b0;
        zero      = 1'b0;
        rst_n     = 1'b0;
        #2;
        chk("rst_slot", slot, 0);
        chk("rst_keyon", keyon_I, 0);
        chk("rst_lvl", fifo_lvl, 0);
        chk("rst_drop", drop_err, 0);
        chk("rst_ready", cmd_ready, 1);
        m_q.delete();
        for (int i = 0; i < NS; i++) m_kon[i] = 1'b0;
        m_slot = 0;
        m_key  = 0;
        m_drop = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Basic key-on: ch1 all operators -> slots 1, 7, 13, 19.
        ftick(1'b1, 3'd1, 4'b1111);
        frames(1);
        wait_slot(1);  chk("basic_s1", keyon_I, 1);
        wait_slot(2);  chk("basic_s2", keyon_I, 0);
        wait_slot(7);  chk("basic_s7", keyon_I, 1);
        wait_slot(13); chk("basic_s13", keyon_I, 1);
        wait_slot(19); chk("basic_s19", keyon_I, 1);
        frames(1);
        wait_slot(7);  chk("persist_s7", keyon_I, 1);

        // Operator mapping: code 4 (ch3), S2 only -> slot 15.
        ftick(1'b1, 3'd4, 4'b0010);
        frames(1);
        wait_slot(15); chk("map_s15", keyon_I, 1);
        wait_slot(21); chk("map_s21", keyon_I, 0);
        wait_slot(3);  chk("map_s3", keyon_I, 0);
        wait_slot(9);  chk("map_s9", keyon_I, 0);

        // One command per frame.
        ftick(1'b1, 3'd0, 4'b1111);
        ftick(1'b1, 3'd0, 4'b0000);
        ftick(1'b1, 3'd0, 4'b1111);
        chk("opf_lvl3", fifo_lvl, 3);
        wait_slot(0); chk("opf_f1", keyon_I, 1); chk("opf_lvl2", fifo_lvl, 2);
        ftick(1'b0, 3'd0, 4'd0);
        wait_slot(0); chk("opf_f2", keyon_I, 0); chk("opf_lvl1", fifo_lvl, 1);
        ftick(1'b0, 3'd0, 4'd0);
        wait_slot(0); chk("opf_f3", keyon_I, 1); chk("opf_lvl0", fifo_lvl, 0);

        // Full FIFO, refused push, simultaneous pop, invalid codes.
        repeat (4) tick(1'b1, 3'd2, 4'b0101, 1'b0, 1'b0);
        chk("full_ready", cmd_ready, 0);
        repeat (2) tick(1'b1, 3'd5, 4'b1111, 1'b0, 1'b0);
        tick(1'b1, 3'd5, 4'b1111, 1'b1, 1'b1);
        chk("full_pop_refused", fifo_lvl, 3);
        tick(1'b1, 3'd5, 4'b1111, 1'b1, 1'b0);
        chk("full_refill", fifo_lvl, 4);
        frames(2);
        ftick(1'b1, 3'd3, 4'b1111);
        chk("inv3_drop", drop_err, 1);
        ftick(1'b1, 3'd7, 4'b1111);
        chk("inv7_drop", drop_err, 1);
        ftick(1'b0, 3'd0, 4'd0);
        chk("inv_drop_clear", drop_err, 0);
        frames(3);

        // Gating and resynchronisation.
        wait_slot(5);
        repeat (10) tick(1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
        chk("gate_slot", slot, 5);
        wait_slot(9);
        tick(1'b0, 3'd0, 4'd0, 1'b1, 1'b1);
        chk("resync_slot", slot, 0);

        // Randomised traffic with occasional stray frame strobes.
        for (int i = 0; i < 1500; i++) begin
            bit       v;
            bit       en;
            bit       z;
            bit [2:0] ch;
            bit [3:0] op;
            v  = ($urandom % 3) == 0;
            ch = 3'($urandom);
            op = 4'($urandom);
            en = ($urandom % 4) != 0;
            z  = (m_slot == NS - 1) ? (($urandom % 8) != 0) : (($urandom % 32) == 0);
            tick(v, ch, op, en, z);
        end

        // Reset with keys on and commands queued.
        frames(5);
        ftick(1'b1, 3'd2, 4'b1111);
        frames(1);
        repeat (3) tick(1'b1, 3'd6, 4'b1111, 1'b0, 1'b0);
        chk("pre_rst_lvl", fifo_lvl, 3);
        do_reset();
        frames(5);
        wait_slot(2);  chk("post_rst_s2", keyon_I, 0);
        wait_slot(11); chk("post_rst_s11", keyon_I, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
